// File: rtl/spi_tx_sched.sv
// Queues 10-bit LCD words and issues them to the SPI driver one at a time,
// tracking completion through the driver's chip-select and enforcing an idle gap.
module spi_tx_sched #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [9:0]        wr_data,
    input  logic              clr_err,
    input  logic              spi_cs_n,
    output logic              spi_start,
    output logic [9:0]        spi_din,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              busy,
    output logic              overflow,
    output logic              timeout_err
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_LOW  = 2'd1;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

    localparam logic [7:0]      TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0]      GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W + 1)'(DEPTH);

    logic [9:0]        fifo_mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [1:0]        state_q, state_d;
    logic [7:0]        tmo_cnt_q, tmo_cnt_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic              spi_start_q, spi_start_d;
    logic [9:0]        spi_din_q, spi_din_d;
    logic              overflow_q, overflow_d;
    logic              timeout_err_q, timeout_err_d;

    logic              full_w;
    logic              empty_w;
    logic              push_ok;
    logic              pop;
    logic              tmo_hit;
    logic [9:0]        head_word;

    assign full_w    = (level_q == DEPTH_LVL);
    assign empty_w   = (level_q == '0);
    // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
    assign push_ok   = wr_en && !full_w;
    assign pop       = (state_q == ST_IDLE) && !empty_w;
    assign head_word = fifo_mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push_ok && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        spi_start_d = 1'b0;
        spi_din_d   = spi_din_q;
        tmo_hit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    spi_start_d = 1'b1;
                    spi_din_d   = head_word;
                    tmo_cnt_d   = 8'd0;
                    gap_cnt_d   = 8'd0;
                    // Power-on commands never toggle CS, so skip straight to the gap.
                    state_d     = head_word[9] ? ST_GAP : ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (!spi_cs_n) begin
                    state_d = ST_WAIT_HIGH;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    gap_cnt_d = 8'd0;
                    state_d   = ST_GAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            ST_WAIT_HIGH: begin
                if (spi_cs_n) begin
                    gap_cnt_d = 8'd0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Set events take priority over a simultaneous clear.
    always_comb begin
        overflow_d    = clr_err ? 1'b0 : overflow_q;
        timeout_err_d = clr_err ? 1'b0 : timeout_err_q;
        if (wr_en && full_w) begin
            overflow_d = 1'b1;
        end
        if (tmo_hit) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            state_q       <= ST_IDLE;
            tmo_cnt_q     <= 8'd0;
            gap_cnt_q     <= 8'd0;
            spi_start_q   <= 1'b0;
            spi_din_q     <= 10'd0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            state_q       <= state_d;
            tmo_cnt_q     <= tmo_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            spi_start_q   <= spi_start_d;
            spi_din_q     <= spi_din_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign spi_start   = spi_start_q;
    assign spi_din     = spi_din_q;
    assign full        = full_w;
    assign empty       = empty_w;
    assign level       = level_q;
    assign busy        = (state_q != ST_IDLE) || !empty_w;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_spi_tx_sched.sv
// Bench for spi_tx_sched: directed and random traffic against a timestamp-based
// reference model, with a simple SPI driver emulation producing chip-select.
module tb_spi_tx_sched;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int GAP    = 8;
    localparam int TMO    = 64;

    localparam int M_NORMAL = 0;
    localparam int M_STALL  = 1;
    localparam int M_HIGH   = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [9:0]        wr_data = 10'd0;
    logic              clr_err = 1'b0;
    logic              spi_cs_n = 1'b1;
    logic              spi_start;
    logic [9:0]        spi_din;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              busy;
    logic              overflow;
    logic              timeout_err;

    spi_tx_sched #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .clr_err(clr_err), .spi_cs_n(spi_cs_n), .spi_start(spi_start),
        .spi_din(spi_din), .full(full), .empty(empty), .level(level),
        .busy(busy), .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: queued words plus edge timestamps of issue and earliest next issue.
    logic [9:0] mq[$];
    int         edge_n = 0;
    int         ready_edge = 0;
    int         issue_edge = 0;
    bit         pend = 1'b0;
    bit         seen_low = 1'b0;
    bit         m_start = 1'b0;
    bit         m_ovf = 1'b0;
    bit         m_tmo = 1'b0;
    logic [9:0] m_din = 10'd0;

    int mode = M_NORMAL;
    int low_from = 0;
    int low_until = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    function automatic bit model_idle();
        return !pend && (edge_n >= ready_edge - 1);
    endfunction

    task automatic model_step();
        bit was_full;
        bit set_ovf;
        bit set_tmo;
        edge_n++;
        if (reset) begin
            mq.delete();
            pend = 1'b0; seen_low = 1'b0; ready_edge = 0;
            m_start = 1'b0; m_din = 10'd0; m_ovf = 1'b0; m_tmo = 1'b0;
            return;
        end
        was_full = (mq.size() == DEPTH);
        set_ovf = 1'b0;
        set_tmo = 1'b0;
        m_start = 1'b0;
        if (pend) begin
            if (!seen_low) begin
                if (spi_cs_n == 1'b0) begin
                    seen_low = 1'b1;
                end else if (edge_n == issue_edge + TMO) begin
                    set_tmo = 1'b1;
                    pend = 1'b0;
                    ready_edge = edge_n + GAP + 1;
                end
            end else if (spi_cs_n == 1'b1) begin
                pend = 1'b0;
                ready_edge = edge_n + GAP + 1;
            end
        end else if (mq.size() > 0 && edge_n >= ready_edge) begin
            m_din = mq.pop_front();
            m_start = 1'b1;
            issue_edge = edge_n;
            if (m_din[9]) begin
                ready_edge = edge_n + GAP + 1;
            end else begin
                pend = 1'b1;
                seen_low = 1'b0;
            end
        end
        if (wr_en) begin
            if (was_full) set_ovf = 1'b1;
            else mq.push_back(wr_data);
        end
        m_ovf = set_ovf ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
        m_tmo = set_tmo ? 1'b1 : (clr_err ? 1'b0 : m_tmo);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("spi_start", 32'(spi_start), 32'(m_start));
        chk("spi_din", 32'(spi_din), 32'(m_din));
        chk("level", 32'(level), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("busy", 32'(busy), 32'(!model_idle() || mq.size() > 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
        if (spi_start && !spi_din[9] && mode == M_NORMAL) begin
            low_from  = edge_n + 1 + int'($urandom_range(0, 2));
            low_until = low_from + int'($urandom_range(6, 20));
        end
        if (mode == M_STALL) spi_cs_n = 1'b0;
        else if (mode == M_HIGH) spi_cs_n = 1'b1;
        else spi_cs_n = !((edge_n + 1) >= low_from && (edge_n + 1) < low_until);
        wr_en = 1'b0;
        clr_err = 1'b0;
        reset = 1'b0;
    endtask

    task automatic push(input logic [9:0] w);
        wr_en = 1'b1;
        wr_data = w;
        tick();
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while ((mq.size() > 0 || !model_idle()) && i < budget) begin
            tick();
            i++;
        end
        checks++;
        assert (mq.size() == 0 && model_idle()) else begin
            failures++;
            $error("FAIL drain: budget %0d expired with %0d words left", budget, mq.size());
        end
    endtask

    task automatic run_timeout(input bit clr_on_hit);
        int i;
        mode = M_HIGH;
        spi_cs_n = 1'b1;
        push(10'h033);
        i = 0;
        while ((mq.size() > 0 || pend) && i < 300) begin
            if (clr_on_hit && pend && !seen_low && (edge_n + 1 == issue_edge + TMO)) clr_err = 1'b1;
            tick();
            i++;
        end
        chk("timeout_sticky", 32'(timeout_err), 32'd1);
        drain(100);
        mode = M_NORMAL;
    endtask

    initial begin
        reset = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);

        push(10'h0AF);
        tick();
        chk("first_start", 32'(spi_start), 32'd1);
        chk("first_din", 32'(spi_din), 32'h0AF);
        drain(200);

        push(10'h1A5);
        push(10'h15A);
        push(10'h0FF);
        drain(400);

        push(10'h200);
        push(10'h0C3);
        drain(300);

        mode = M_STALL;
        for (int i = 0; i < 18; i++) push(10'($urandom) & 10'h1FF);
        chk("stall_full", 32'(full), 32'd1);
        chk("stall_level", 32'(level), 32'd16);
        chk("stall_overflow", 32'(overflow), 32'd1);
        mode = M_NORMAL;
        drain(3000);
        clr_err = 1'b1;
        tick();
        chk("ovf_cleared", 32'(overflow), 32'd0);

        run_timeout(1'b0);
        clr_err = 1'b1;
        tick();
        run_timeout(1'b1);
        clr_err = 1'b1;
        tick();

        for (int i = 0; i < 600; i++) begin
            mode = ((i % 150) < 120) ? M_NORMAL : M_HIGH;
            if ($urandom_range(0, 3) == 0) begin
                wr_en = 1'b1;
                wr_data = 10'($urandom);
                wr_data[9] = ($urandom_range(0, 5) == 0);
            end
            if ($urandom_range(0, 19) == 0) clr_err = 1'b1;
            tick();
        end
        mode = M_NORMAL;
        drain(5000);

        mode = M_STALL;
        for (int i = 0; i < 6; i++) push(10'h055 + 10'(i));
        tick();
        chk("pre_reset_level", 32'(level), 32'd5);
        reset = 1'b1;
        tick();
        chk("post_reset_level", 32'(level), 32'd0);
        chk("post_reset_empty", 32'(empty), 32'd1);
        chk("post_reset_start", 32'(spi_start), 32'd0);
        mode = M_NORMAL;
        for (int i = 0; i < 30; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
